// File: rtl/jtag_param_tap.sv
`timescale 1ns/1ps
// IEEE 1149.1 TAP: 16-state controller, parametrised IR, BYPASS/IDCODE/user DR mux.
// tdo_o is combinational from registered state; every state change is on the tck_i rising edge.
module jtag_param_tap #(
    parameter int          IR_WIDTH    = 4,
    parameter int          DR_WIDTH    = 8,
    parameter int          NUM_USER_DR = 2,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001
) (
    input  logic                            tck_i,
    input  logic                            rst_ni,
    input  logic                            tms_i,
    input  logic                            tdi_i,
    output logic                            tdo_o,
    output logic                            tdo_en_o,
    output logic [3:0]                      state_o,
    output logic [IR_WIDTH-1:0]             instruction_o,
    input  logic [NUM_USER_DR*DR_WIDTH-1:0] cdr_data_i,
    output logic [NUM_USER_DR*DR_WIDTH-1:0] udr_data_o,
    output logic [NUM_USER_DR-1:0]          udr_valid_o
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    tap_state_e                      state_q, state_d;
    logic [IR_WIDTH-1:0]             ir_sr;
    logic [IR_WIDTH-1:0]             instruction_q;
    logic                            bypass_sr;
    logic [31:0]                     idcode_sr;
    logic [DR_WIDTH-1:0]             user_sr [NUM_USER_DR];
    logic [NUM_USER_DR*DR_WIDTH-1:0] udr_data_q;
    logic [NUM_USER_DR-1:0]          udr_valid_q;

    logic                            sel_idcode;
    logic [NUM_USER_DR-1:0]          sel_user;
    logic [NUM_USER_DR-1:0]          user_lsbs;
    logic                            dr_lsb;

    always_ff @(posedge tck_i) begin
        if (!rst_ni) state_q <= TLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms_i ? TLR    : RTI;
            RTI:    state_d = tms_i ? SEL_DR : RTI;
            SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms_i ? SEL_DR : RTI;
            SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms_i ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Anything that is neither IDCODE nor a user code falls through to BYPASS.
    always_comb begin
        sel_idcode = (instruction_q == IR_WIDTH'(1));
        sel_user   = '0;
        user_lsbs  = '0;
        for (int k = 0; k < NUM_USER_DR; k++) begin
            sel_user[k]  = (instruction_q == IR_WIDTH'(k + 2));
            user_lsbs[k] = user_sr[k][0];
        end
    end

    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_idcode)     dr_lsb = idcode_sr[0];
        else if (|sel_user) dr_lsb = |(sel_user & user_lsbs);
    end

    always_ff @(posedge tck_i) begin
        if (!rst_ni) begin
            ir_sr         <= '0;
            instruction_q <= IR_WIDTH'(1);
            bypass_sr     <= 1'b0;
            idcode_sr     <= '0;
            udr_data_q    <= '0;
            udr_valid_q   <= '0;
            for (int k = 0; k < NUM_USER_DR; k++) user_sr[k] <= '0;
        end else begin
            udr_valid_q <= '0;
            case (state_q)
                TLR:    instruction_q <= IR_WIDTH'(1);
                CAP_IR: ir_sr <= IR_WIDTH'(1);
                SH_IR:  ir_sr <= {tdi_i, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: instruction_q <= ir_sr;
                CAP_DR: begin
                    if (sel_idcode) idcode_sr <= IDCODE_VAL;
                    else if (|sel_user) begin
                        for (int k = 0; k < NUM_USER_DR; k++)
                            if (sel_user[k]) user_sr[k] <= cdr_data_i[k*DR_WIDTH +: DR_WIDTH];
                    end else bypass_sr <= 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode) idcode_sr <= {tdi_i, idcode_sr[31:1]};
                    else if (|sel_user) begin
                        // Shift expressed arithmetically so DR_WIDTH=1 elaborates.
                        for (int k = 0; k < NUM_USER_DR; k++)
                            if (sel_user[k])
                                user_sr[k] <= (user_sr[k] >> 1) | (DR_WIDTH'(tdi_i) << (DR_WIDTH - 1));
                    end else bypass_sr <= tdi_i;
                end
                UPD_DR: begin
                    for (int k = 0; k < NUM_USER_DR; k++) begin
                        if (sel_user[k]) begin
                            udr_data_q[k*DR_WIDTH +: DR_WIDTH] <= user_sr[k];
                            udr_valid_q[k]                     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tdo_en_o      = (state_q == SH_IR) || (state_q == SH_DR);
    assign tdo_o         = (state_q == SH_IR) ? ir_sr[0] : (state_q == SH_DR) ? dr_lsb : 1'b0;
    assign state_o       = state_q;
    assign instruction_o = instruction_q;
    assign udr_data_o    = udr_data_q;
    assign udr_valid_o   = udr_valid_q;

endmodule

// File: tb/tb_jtag_param_tap.sv
`timescale 1ns/1ps
// Bench for jtag_param_tap: directed scenarios plus a long random walk against a table-driven model.
module tb_jtag_param_tap;
    localparam int IR = 4;
    localparam int DR = 8;
    localparam int NU = 2;

    logic            tck, rst_n, tms, tdi, tdo, tdo_en;
    logic [3:0]      state;
    logic [IR-1:0]   instr;
    logic [NU*DR-1:0] cdr, udr;
    logic [NU-1:0]   uvld;

    int n_cmp = 0;
    int n_fail = 0;

    jtag_param_tap #(.IR_WIDTH(IR), .DR_WIDTH(DR), .NUM_USER_DR(NU), .IDCODE_VAL(32'h1000_0001)) dut (
        .tck_i(tck), .rst_ni(rst_n), .tms_i(tms), .tdi_i(tdi), .tdo_o(tdo), .tdo_en_o(tdo_en),
        .state_o(state), .instruction_o(instr), .cdr_data_i(cdr), .udr_data_o(udr), .udr_valid_o(uvld)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Model: next-state tables indexed by the standard state numbers, registers as plain integers.
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int     m_state, m_instr, m_uvld;
    longint m_ir, m_byp, m_id;
    longint m_usr [NU];
    longint m_udr [NU];

    logic p_tdo, p_en, e_tdo, e_en;
    logic [3:0] p_state, e_state;
    logic [IR-1:0] ir_out;
    logic [63:0]   dr_out;

    function automatic int user_idx();
        return (m_instr >= 2 && m_instr < 2 + NU) ? m_instr - 2 : -1;
    endfunction

    function automatic logic model_tdo();
        int k = user_idx();
        if (m_state == 11) return (m_ir & 1) != 0;
        if (m_state != 4)  return 1'b0;
        if (m_instr == 1)  return (m_id & 1) != 0;
        if (k >= 0)        return (m_usr[k] & 1) != 0;
        return (m_byp & 1) != 0;
    endfunction

    function automatic logic [NU*DR-1:0] model_udr();
        logic [NU*DR-1:0] v;
        for (int k = 0; k < NU; k++) v[k*DR +: DR] = DR'(m_udr[k]);
        return v;
    endfunction

    function automatic void model_edge(input logic t, input logic d, input logic r);
        int k = user_idx();
        if (!r) begin
            m_state = 0; m_instr = 1; m_uvld = 0; m_ir = 0; m_byp = 0; m_id = 0;
            for (int j = 0; j < NU; j++) begin m_usr[j] = 0; m_udr[j] = 0; end
            return;
        end
        m_uvld = 0;
        case (m_state)
            0:  m_instr = 1;
            10: m_ir = 1;
            11: m_ir = (m_ir >> 1) | (longint'(d) << (IR - 1));
            15: m_instr = int'(m_ir);
            3: begin
                if (m_instr == 1) m_id = 64'h1000_0001;
                else if (k >= 0)  m_usr[k] = longint'(cdr[k*DR +: DR]);
                else              m_byp = 0;
            end
            4: begin
                if (m_instr == 1) m_id = (m_id >> 1) | (longint'(d) << 31);
                else if (k >= 0)  m_usr[k] = (m_usr[k] >> 1) | (longint'(d) << (DR - 1));
                else              m_byp = longint'(d);
            end
            8: if (k >= 0) begin m_udr[k] = m_usr[k]; m_uvld = 1 << k; end
            default: ;
        endcase
        m_state = t ? nxt1[m_state] : nxt0[m_state];
    endfunction

    // One TCK cycle: drive, sample pre-edge outputs with model predictions, clock both.
    task automatic step(input logic t, input logic d, input logic r);
        @(negedge tck);
        tms = t; tdi = d; rst_n = r;
        #1;
        p_tdo = tdo; p_en = tdo_en; p_state = state;
        e_tdo = model_tdo(); e_en = (m_state == 4 || m_state == 11); e_state = 4'(m_state);
        @(posedge tck);
        model_edge(t, d, r);
        #1;
    endtask

    task automatic load_ir(input int v);
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < IR; i++) begin
            step(i == IR - 1, 1'((v >> i) & 1), 1'b1);
            ir_out[i] = p_tdo;
        end
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] din);
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], 1'b1);
            dr_out[i] = p_tdo;
        end
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (state !== 4'd0)  begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_cmp++; if (instr !== 4'd1)  begin n_fail++; $display("FAIL reset_instr got %0d want 1", instr); end
        n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL reset_tdo_en got %b want 0", tdo_en); end
        n_cmp++; if (tdo !== 1'b0)    begin n_fail++; $display("FAIL reset_tdo got %b want 0", tdo); end
        n_cmp++; if (udr !== '0)      begin n_fail++; $display("FAIL reset_udr got %h want 0", udr); end
        n_cmp++; if (uvld !== '0)     begin n_fail++; $display("FAIL reset_uvld got %b want 0", uvld); end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++; if (state !== 4'd1)  begin n_fail++; $display("FAIL reset_to_rti got %0d want 1", state); end
    endtask

    task automatic test_idcode();
        shift_dr(32, {$urandom, $urandom});
        n_cmp++; if (dr_out[31:0] !== 32'h1000_0001) begin n_fail++; $display("FAIL idcode_stream got %h want 10000001", dr_out[31:0]); end
        n_cmp++; if (instr !== 4'd1) begin n_fail++; $display("FAIL idcode_instr got %0d want 1", instr); end
    endtask

    task automatic test_bypass();
        load_ir(15);
        n_cmp++; if (instr !== 4'hF) begin n_fail++; $display("FAIL bypass_instr got %h want f", instr); end
        shift_dr(4, 64'b1101);
        n_cmp++; if (dr_out[3:0] !== 4'b1010) begin n_fail++; $display("FAIL bypass_stream got %b want 1010", dr_out[3:0]); end
    endtask

    task automatic test_user0();
        logic [DR-1:0] ch1_before;
        cdr = {8'h5E, 8'hA5};
        ch1_before = udr[2*DR-1:DR];
        load_ir(2);
        shift_dr(8, 64'h3C);
        n_cmp++; if (dr_out[7:0] !== 8'hA5) begin n_fail++; $display("FAIL user0_capture got %h want a5", dr_out[7:0]); end
        n_cmp++; if (udr[DR-1:0] !== 8'h3C) begin n_fail++; $display("FAIL user0_update got %h want 3c", udr[DR-1:0]); end
        n_cmp++; if (uvld !== 2'b01) begin n_fail++; $display("FAIL user0_strobe got %b want 01", uvld); end
        n_cmp++; if (udr[2*DR-1:DR] !== ch1_before) begin n_fail++; $display("FAIL user0_ch1 got %h want %h", udr[2*DR-1:DR], ch1_before); end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++; if (uvld !== 2'b00) begin n_fail++; $display("FAIL user0_strobe_len got %b want 00", uvld); end
    endtask

    task automatic test_ir_capture();
        load_ir(7);
        n_cmp++; if (ir_out[1:0] !== 2'b01) begin n_fail++; $display("FAIL ir_capture got %b want 01", ir_out[1:0]); end
        n_cmp++; if (instr !== 4'd7) begin n_fail++; $display("FAIL ir_undef_instr got %0d want 7", instr); end
        shift_dr(5, 64'b10110);
        n_cmp++; if (dr_out[4:0] !== 5'b01100) begin n_fail++; $display("FAIL undef_bypass got %b want 01100", dr_out[4:0]); end
    endtask

    task automatic test_tlr_escape();
        cdr = 16'($urandom);
        load_ir(3);
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            n_cmp++; if (uvld !== NU'(m_uvld)) begin n_fail++; $display("FAIL tlr_strobe[%0d] got %b want %b", i, uvld, NU'(m_uvld)); end
        end
        n_cmp++; if (state !== 4'd0) begin n_fail++; $display("FAIL tlr_reach got %0d want 0", state); end
        n_cmp++; if (udr !== model_udr()) begin n_fail++; $display("FAIL tlr_udr got %h want %h", udr, model_udr()); end
        step(1'b1, 1'b0, 1'b1);
        n_cmp++; if (instr !== 4'd1) begin n_fail++; $display("FAIL tlr_instr got %0d want 1", instr); end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause_reset();
        load_ir(2);
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        n_cmp++; if (state !== 4'd6) begin n_fail++; $display("FAIL pause_state got %0d want 6", state); end
        step(1'b1, 1'b0, 1'b0);
        n_cmp++; if (state !== 4'd0)  begin n_fail++; $display("FAIL pause_rst_state got %0d want 0", state); end
        n_cmp++; if (udr !== '0)      begin n_fail++; $display("FAIL pause_rst_udr got %h want 0", udr); end
        n_cmp++; if (uvld !== '0)     begin n_fail++; $display("FAIL pause_rst_uvld got %b want 0", uvld); end
        n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL pause_rst_tdo_en got %b want 0", tdo_en); end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cdr = 16'($urandom);
            step($urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)), $urandom_range(0, 299) != 0);
            n_cmp++; if (p_tdo !== e_tdo)     begin n_fail++; $display("FAIL rnd_tdo step %0d got %b want %b", i, p_tdo, e_tdo); end
            n_cmp++; if (p_en !== e_en)       begin n_fail++; $display("FAIL rnd_tdo_en step %0d got %b want %b", i, p_en, e_en); end
            n_cmp++; if (p_state !== e_state) begin n_fail++; $display("FAIL rnd_state step %0d got %0d want %0d", i, p_state, e_state); end
            n_cmp++; if (instr !== IR'(m_instr)) begin n_fail++; $display("FAIL rnd_instr step %0d got %0d want %0d", i, instr, m_instr); end
            n_cmp++; if (udr !== model_udr()) begin n_fail++; $display("FAIL rnd_udr step %0d got %h want %h", i, udr, model_udr()); end
            n_cmp++; if (uvld !== NU'(m_uvld)) begin n_fail++; $display("FAIL rnd_uvld step %0d got %b want %b", i, uvld, NU'(m_uvld)); end
        end
    endtask

    initial begin
        rst_n = 1'b0; tms = 1'b1; tdi = 1'b0; cdr = '0;
        test_reset();
        test_idcode();
        test_bypass();
        test_user0();
        test_ir_capture();
        test_tlr_escape();
        test_pause_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
